// File: rtl/traffic_phase_sequencer.sv
// ---------------------------------------------------------------------------
// traffic_phase_sequencer
//
// Single-clock traffic-light phase controller. It cycles
// RED -> GREEN -> YELLOW -> RED, and all phase timing counts 1 Hz ticks.
// It also provides:
//   - a latched pedestrian request that can cut GREEN short once MIN_GREEN
//     ticks of GREEN have elapsed
//   - a walk lamp that is lit during RED
//   - a flashing-red night mode
//
// Ports
//   clk          system clock; every state change happens on its rising edge
//   reset        asynchronous, active-high reset
//   tick         single-cycle enable, one per second
//   btn          pedestrian button (asynchronous level input)
//   night        night-mode select, synchronous to clk
//   lights       00 off, 01 red, 10 green, 11 yellow (registered)
//   walk         pedestrian walk lamp (registered)
//   req_pending  a pedestrian request is latched and not yet served
//   phase_cnt    ticks elapsed in the current phase
// ---------------------------------------------------------------------------
module traffic_phase_sequencer #(
  parameter int RED_LEN    = 10,
  parameter int GREEN_LEN  = 10,
  parameter int YELLOW_LEN = 2,
  parameter int MIN_GREEN  = 3,
  parameter int CNT_W      = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             btn,
  input  logic             night,
  output logic [1:0]       lights,
  output logic             walk,
  output logic             req_pending,
  output logic [CNT_W-1:0] phase_cnt
);

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_RED    = 3'd1,
    S_GREEN  = 3'd2,
    S_YELLOW = 3'd3,
    S_FLASH  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] RED_LAST    = CNT_W'(RED_LEN - 1);
  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_LEN - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_LEN - 1);
  localparam logic [CNT_W-1:0] MIN_LAST    = CNT_W'(MIN_GREEN - 1);

  localparam logic [1:0] L_OFF    = 2'b00;
  localparam logic [1:0] L_RED    = 2'b01;
  localparam logic [1:0] L_GREEN  = 2'b10;
  localparam logic [1:0] L_YELLOW = 2'b11;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       lights_q, lights_d;
  logic             walk_q, walk_d;
  logic             req_q, req_d;
  logic             sync1_q, sync2_q, prev_q;
  logic             btn_edge;

  assign lights      = lights_q;
  assign walk        = walk_q;
  assign req_pending = req_q;
  assign phase_cnt   = cnt_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lights_d = lights_q;
    walk_d   = walk_q;
    req_d    = req_q;

    // Rising edge of the synchronised button. This is evaluated every clk,
    // independent of tick.
    btn_edge = sync2_q & ~prev_q;

    // The walk lamp is already on in RED, so a press there is not latched.
    if (btn_edge && (state_q != S_RED)) begin
      req_d = 1'b1;
    end

    if (tick) begin
      if (night && (state_q != S_FLASH)) begin
        state_d = S_FLASH;
        cnt_d   = '0;
      end else if (state_q == S_FLASH) begin
        cnt_d = '0;
        if (!night) begin
          state_d = S_RED;
        end
      end else begin
        case (state_q)
          S_INIT: begin
            state_d = S_RED;
            cnt_d   = '0;
          end
          S_RED: begin
            if (cnt_q == RED_LAST) begin
              state_d = S_GREEN;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          S_GREEN: begin
            // A pending request ends GREEN early, but only after the
            // minimum green time has elapsed.
            if ((req_q && (cnt_q >= MIN_LAST)) || (cnt_q == GREEN_LAST)) begin
              state_d = S_YELLOW;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          S_YELLOW: begin
            if (cnt_q == YELLOW_LAST) begin
              state_d = S_RED;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          default: begin
            state_d = S_INIT;
            cnt_d   = '0;
          end
        endcase
      end

      case (state_d)
        S_RED:    lights_d = L_RED;
        S_GREEN:  lights_d = L_GREEN;
        S_YELLOW: lights_d = L_YELLOW;
        S_FLASH: begin
          // Entering FLASH shows red. After that, red blinks on every tick.
          if (state_q != S_FLASH) begin
            lights_d = L_RED;
          end else begin
            lights_d = (lights_q == L_RED) ? L_OFF : L_RED;
          end
        end
        default:  lights_d = L_OFF;
      endcase

      walk_d = (state_d == S_RED);

      // The YELLOW -> RED transition is the one that serves a request, so it
      // clears the latch. It also wins over a same-edge button press. A RED
      // reached from FLASH or INIT keeps the request, and the request is
      // then served in the following GREEN.
      if ((state_q == S_YELLOW) && (state_d == S_RED)) begin
        req_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_INIT;
      cnt_q    <= '0;
      lights_q <= L_OFF;
      walk_q   <= 1'b0;
      req_q    <= 1'b0;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      prev_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lights_q <= lights_d;
      walk_q   <= walk_d;
      req_q    <= req_d;
      sync1_q  <= btn;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
    end
  end

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// ---------------------------------------------------------------------------
// tb_traffic_phase_sequencer
//
// Directed bench for traffic_phase_sequencer with its default parameters.
// Inputs change 1 ns after a rising clk edge, and outputs are sampled at the
// same point, so values are observed well away from the active edge.
// ---------------------------------------------------------------------------
module tb_traffic_phase_sequencer;

  logic       clk;
  logic       reset;
  logic       tick;
  logic       btn;
  logic       night;
  logic [1:0] lights;
  logic       walk;
  logic       req_pending;
  logic [4:0] phase_cnt;

  int n_checks;
  int n_pass;
  int tick_no;

  traffic_phase_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .btn         (btn),
    .night       (night),
    .lights      (lights),
    .walk        (walk),
    .req_pending (req_pending),
    .phase_cnt   (phase_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [1:0] exp_l,
                           input logic exp_w, input int exp_c);
    check({tag, ".lights"}, 32'(lights), 32'(exp_l));
    check({tag, ".walk"}, 32'(walk), 32'(exp_w));
    check({tag, ".cnt"}, 32'(phase_cnt), 32'(exp_c));
  endtask

  // Called 1 ns after a rising edge. Returns 1 ns after the next edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_tick();
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
    tick_no++;
    $display("tick %0d: lights=%b walk=%b req=%b cnt=%0d",
             tick_no, lights, walk, req_pending, phase_cnt);
  endtask

  task automatic ticks(input int n);
    repeat (n) do_tick();
  endtask

  task automatic pulse_btn();
    btn = 1'b1;
    idle(1);
    btn = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    tick_no  = 0;
    reset    = 1'b1;
    tick     = 1'b0;
    btn      = 1'b0;
    night    = 1'b0;

    // Reset state
    idle(3);
    check_out("rst", 2'b00, 1'b0, 0);
    check("rst.req", 32'(req_pending), 32'd0);
    reset = 1'b0;
    idle(2);
    check("pre_tick.lights", 32'(lights), 32'd0);

    // One full default cycle plus the next RED: RED 10, GREEN 10, YELLOW 2
    for (int t = 1; t <= 23; t++) begin
      do_tick();
      if (t <= 10)      check_out($sformatf("cyc%0d", t), 2'b01, 1'b1, t - 1);
      else if (t <= 20) check_out($sformatf("cyc%0d", t), 2'b10, 1'b0, t - 11);
      else if (t <= 22) check_out($sformatf("cyc%0d", t), 2'b11, 1'b0, t - 21);
      else              check_out($sformatf("cyc%0d", t), 2'b01, 1'b1, 0);
    end

    // Finish RED, then press the button at GREEN phase_cnt=0
    ticks(9);
    do_tick();
    check_out("g_entry", 2'b10, 1'b0, 0);
    pulse_btn();
    idle(1);
    check("req_2clk", 32'(req_pending), 32'd0);
    idle(1);
    check("req_3clk", 32'(req_pending), 32'd1);
    do_tick();
    check_out("early_g1", 2'b10, 1'b0, 1);
    do_tick();
    check_out("early_g2", 2'b10, 1'b0, 2);
    do_tick();
    check_out("early_y0", 2'b11, 1'b0, 0);
    check("early_y0.req", 32'(req_pending), 32'd1);
    do_tick();
    check_out("early_y1", 2'b11, 1'b0, 1);
    do_tick();
    check_out("early_red", 2'b01, 1'b1, 0);
    check("early_red.req", 32'(req_pending), 32'd0);

    // A press during RED is ignored, and RED still lasts 10 ticks
    pulse_btn();
    idle(3);
    check("red_btn.req", 32'(req_pending), 32'd0);
    ticks(9);
    check_out("red_last", 2'b01, 1'b1, 9);
    do_tick();
    check_out("red_to_g", 2'b10, 1'b0, 0);

    // Press at GREEN phase_cnt=7 while holding btn high for 50 clks
    ticks(7);
    check_out("g7", 2'b10, 1'b0, 7);
    btn = 1'b1;
    idle(50);
    check("hold.req", 32'(req_pending), 32'd1);
    do_tick();
    check_out("late_y0", 2'b11, 1'b0, 0);
    ticks(2);
    check_out("late_red", 2'b01, 1'b1, 0);
    check("late_red.req", 32'(req_pending), 32'd0);
    idle(10);
    check("hold_red.req", 32'(req_pending), 32'd0);
    btn = 1'b0;
    idle(3);
    ticks(10);
    check_out("hold_g", 2'b10, 1'b0, 0);
    check("hold_g.req", 32'(req_pending), 32'd0);

    // Night mode entered mid-GREEN
    ticks(4);
    night = 1'b1;
    do_tick();
    check_out("fl0", 2'b01, 1'b0, 0);
    do_tick();
    check_out("fl1", 2'b00, 1'b0, 0);
    do_tick();
    check_out("fl2", 2'b01, 1'b0, 0);
    pulse_btn();
    idle(3);
    check("fl.req", 32'(req_pending), 32'd1);
    do_tick();
    check_out("fl3", 2'b00, 1'b0, 0);
    night = 1'b0;
    do_tick();
    check_out("fl_exit", 2'b01, 1'b1, 0);
    check("fl_exit.req", 32'(req_pending), 32'd1);
    ticks(9);
    check_out("fl_red9", 2'b01, 1'b1, 9);
    do_tick();
    check_out("fl_g0", 2'b10, 1'b0, 0);
    ticks(2);
    check_out("fl_g2", 2'b10, 1'b0, 2);
    do_tick();
    check_out("fl_y0", 2'b11, 1'b0, 0);
    ticks(2);
    check("fl_red.req", 32'(req_pending), 32'd0);

    // The button edge lands on the YELLOW->RED edge, so RED entry wins
    ticks(10);
    ticks(10);
    do_tick();
    check_out("col_y1", 2'b11, 1'b0, 1);
    btn = 1'b1;
    idle(2);
    check("col_pre.req", 32'(req_pending), 32'd0);
    do_tick();
    check_out("col_red", 2'b01, 1'b1, 0);
    check("col_red.req", 32'(req_pending), 32'd0);
    btn = 1'b0;

    // Asynchronous reset during YELLOW with a request pending
    ticks(10);
    pulse_btn();
    idle(3);
    ticks(3);
    check_out("ar_y0", 2'b11, 1'b0, 0);
    do_tick();
    check_out("ar_y1", 2'b11, 1'b0, 1);
    check("ar_y1.req", 32'(req_pending), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_out("async_rst", 2'b00, 1'b0, 0);
    check("async_rst.req", 32'(req_pending), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(2);
    do_tick();
    check_out("post_rst", 2'b01, 1'b1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/traffic_phase_sequencer.md
# traffic_phase_sequencer

Parametrised, fully synchronous traffic-light phase controller. It replaces the ripple-clocked light driver with a single-clock design. Phase lengths, counter width and minimum green time are parameters. It adds a latched pedestrian request with a minimum-green guarantee, a pedestrian walk output, and a flashing-red night mode. It sits between the 1 Hz tick generator / button pads and the light output drivers.

## Interface
- RED_LEN, 10: ticks spent in RED (≥1)
- GREEN_LEN, 10: ticks spent in GREEN (≥1)
- YELLOW_LEN, 2: ticks spent in YELLOW (≥1)
- MIN_GREEN, 3: ticks of GREEN that must elapse before a request may cut GREEN short (1..GREEN_LEN)
- CNT_W, 5: phase counter width; must hold max(RED_LEN, GREEN_LEN, YELLOW_LEN)-1
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high reset
- tick  in  1  single-cycle enable, one per second; all phase timing counts ticks
- btn  in  1  pedestrian button, asynchronous, level
- night  in  1  night-mode select, synchronous to clk
- lights  out  2  00 off, 01 red, 10 green, 11 yellow
- walk  out  1  pedestrian walk lamp
- req_pending  out  1  a pedestrian request is latched and not yet served
- phase_cnt  out  CNT_W  ticks elapsed in the current phase

## Operation
- States: INIT, RED, GREEN, YELLOW, FLASH. Outputs are registered, decoded from the state.
  - INIT: lights=00
  - RED: 01, walk=1
  - GREEN: 10
  - YELLOW: 11
  - FLASH: alternates 01/00
- walk=0 in every state except RED.
- Reset (async): state=INIT, lights=00, walk=0, req_pending=0, phase_cnt=0, synchroniser flops=0.
- Nothing changes on a cycle with tick=0, except btn synchronisation and req_pending capture.
- Phase behaviour on a tick, evaluated in priority order:
  1. night=1 and state≠FLASH: go to FLASH, phase_cnt=0, lights=01.
  2. In FLASH with night=1: lights toggle 01↔00, phase_cnt holds 0.
  3. In FLASH with night=0: go to RED, phase_cnt=0.
  4. In INIT: go to RED, phase_cnt=0.
  5. In GREEN with req_pending=1 and phase_cnt ≥ MIN_GREEN-1: go to YELLOW, phase_cnt=0.
  6. phase_cnt == LEN-1 for the current phase: advance RED→GREEN→YELLOW→RED, phase_cnt=0.
  7. Otherwise: phase_cnt+1.
- The counter never wraps: it is compared against LEN-1 and cleared on every phase change.
- btn passes a 2-flop synchroniser, then rising-edge detect.
- An edge sets req_pending in GREEN, YELLOW, INIT or FLASH. Edges in RED are ignored, because walk is already active.
- req_pending clears on entry to RED. Entry to RED has priority over a same-cycle edge: the result is req_pending=0.
- A request latched during FLASH or INIT persists; it is served after FLASH exits, in the next GREEN.
- Holding btn high produces exactly one request.
- The design is fully synchronous apart from reset. No derived or gated clocks.

## Timing
- State, lights, walk and phase_cnt update on the clk edge where tick=1. Latency from tick to output is 1 cycle.
- btn to req_pending is 3 clk edges: two synchroniser edges, then one capture edge. It is independent of tick.
- req_pending=1 on the tick edge that enters RED clears to 0 on that same edge.
- Default full cycle is 22 ticks: RED 10, GREEN 10, YELLOW 2. The first RED starts on the first tick after reset release.
- Fastest request service from GREEN entry: YELLOW on the MIN_GREEN-th tick in GREEN, i.e. the 3rd tick with defaults.
- Reset asserted mid-phase: all outputs go to reset values immediately, without waiting for clk.

## Test plan
- Reset, then 23 ticks with btn=0, night=0:
  - lights=00 before the first tick, then 01 on tick 1
  - 10 on tick 11, 11 on tick 21, 01 on tick 23
  - walk=1 only in RED; phase_cnt counts 0..9, 0..9, 0..1
- btn pulsed early in GREEN (phase_cnt=0):
  - req_pending=1 three clks later
  - YELLOW on the 3rd GREEN tick, then RED 2 ticks later
  - req_pending=0 and walk=1 on RED entry
- btn pulsed at GREEN phase_cnt=7 (beyond MIN_GREEN): YELLOW on the very next tick. btn held high for 50 cycles: exactly one request.
- btn pulsed during RED: req_pending stays 0, the RED length is unchanged at 10 ticks.
- night=1 asserted mid-GREEN:
  - FLASH on the next tick; lights toggle 01/00 each tick
  - a btn press sets req_pending, which persists
  - after night=0: RED for 10 ticks, then GREEN, then early YELLOW at the 3rd GREEN tick
- reset asserted between clk edges during YELLOW with req_pending=1: all outputs reset immediately. Same-edge collision case: a btn edge on the RED-entry edge leaves req_pending=0.
